tdm_demux_1x16: RTL and testbench
=================================

# tdm_demux_1x16

Receive-side demultiplexer for the 16-channel time-division link: takes the single serial bit stream produced by the 16:1 select-driven serializer and sorts each slot into its own output bit. An internal slot counter tracks the serializer's select sequence. A frame-sync marker locks that counter. A completed 16-slot frame is presented as a registered 16-bit word with a one-cycle valid pulse. The block sits directly after the link input stage and feeds per-channel consumers.

## Interface
- `RESYNC`, default 1. Selects the reaction to a sync marker arriving on a nonzero slot: 1 = realign the frame to that marker, 0 = drop back to hunting for sync.
- `clk`, input, 1 bit. The single clock; all state changes on its rising edge.
- `rst`, input, 1 bit. Asynchronous, active-high reset.
- `en`, input, 1 bit. Bit strobe; `din` and `sync_in` are sampled only on cycles where `en` = 1.
- `din`, input, 1 bit. Serial data bit for the current slot.
- `sync_in`, input, 1 bit. Frame marker, asserted together with the slot-0 bit.
- `out`, output, 16 bits. Last complete frame; bit i = channel i.
- `frame_valid`, output, 1 bit. One-cycle pulse when `out` updates.
- `slot`, output, 5 bits. Slot index expected on the next strobe. Bit 4 is 0 unless parity is compiled in.
- `locked`, output, 1 bit. High while the state machine is in RUN.
- `sync_err`, output, 1 bit. One-cycle pulse on a sync violation.
- `par_err`, output, 1 bit. One-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.

## Operation
- Reset values: `out` = 0, `frame_valid` = 0, `slot` = 0, `locked` = 0, `sync_err` = 0, `par_err` = 0, shadow register = 0, state = HUNT.
- States:
  - HUNT: strobes with `sync_in` = 0 are ignored. A strobe with `sync_in` = 1 captures `din` into shadow[0], sets `slot` = 1 and moves to RUN.
  - RUN: each strobe with `sync_in` = 0 on slot k (1..15) captures `din` into shadow[k] and increments `slot`.
- Last data slot (slot 15) strobe:
  - `out` <= {din, shadow[14:0]}, `frame_valid` pulses, `slot` wraps to 0.
  - Parity build: instead of the above, `slot` goes to 16 and the parity rules below apply.
- Slot-0 strobe in RUN:
  - With `sync_in` = 1: normal; shadow[0] <= `din`, `slot` = 1.
  - With `sync_in` = 0: missing sync. `sync_err` pulses, nothing is captured, state goes to HUNT, `slot` = 0.
- Misplaced sync (`sync_in` = 1 on slot k ≠ 0 in RUN): `sync_err` pulses, and the partial frame is discarded (`out` unchanged).
  - `RESYNC` = 1: shadow[0] <= `din`, `slot` = 1, stay in RUN.
  - `RESYNC` = 0: go to HUNT, `slot` = 0.
- Shadow bits are not cleared between frames; only `out` is architecturally visible.
- `en` = 0 cycles hold all state. Strobes may occur on consecutive cycles or be spaced arbitrarily.

## Timing
- All outputs are registered.
- `out`, `frame_valid` and `sync_err` update on the clock edge that samples the triggering strobe, so they are visible one cycle after that strobe is presented.
- `frame_valid`, `sync_err` and `par_err` are high for exactly one cycle per event.
- Back-to-back frames at full rate (`en` held at 1) are supported: 16 cycles per frame, or 17 with parity. `frame_valid` therefore recurs every 16 or 17 cycles with no gap.
- `rst` asserted mid-frame clears all state immediately, with no clock required. The first frame after release requires a new sync.
- Sync on slot 0 in the same strobe that would have been "missing" is not an error. Only the two cases listed under Operation raise `sync_err`.

## Configuration
- `TDM_DEMUX_PARITY_EN` defined:
  - A 17th slot (slot 16) carries even parity over the 16 data bits.
  - The strobe on slot 16 checks `din` against the XOR of shadow[15:0].
  - On a match: `out` updates and `frame_valid` pulses.
  - On a mismatch: `par_err` pulses and `out` is held.
  - In both cases `slot` wraps to 0.
  - `sync_in` = 1 on slot 16 is a misplaced sync.
- Not defined: 16-slot frames, `par_err` tied 0, `slot[4]` always 0.

## Test plan
- Reset, then sync plus 16 strobes carrying 0xA5C3 (LSB = slot 0) → one cycle later `out` = 0xA5C3, `frame_valid` high for one cycle, `locked` = 1, `slot` = 0.
- Continuous `en` = 1 with frames 0x0001 then 0xFFFF, sync on every slot 0 → `frame_valid` pulses 16 cycles apart, `out` = 0x0001 then 0xFFFF, no `sync_err`.
- Valid frame, then slot-0 strobe with `sync_in` = 0 → `sync_err` pulse, `locked` = 0, `out` holds the previous value; the next frame is ignored until a sync arrives.
- `RESYNC` = 1, sync reasserted at slot 7, followed by 15 strobes of 0x1234's remaining bits → `sync_err` at slot 7, then `out` = 0x1234 with no further errors.
- `rst` pulsed at slot 9 mid-frame → all outputs 0 immediately; no `frame_valid` until a fresh sync plus 16 strobes.
- Parity build: frame 0x00FF with parity bit 0 → `out` = 0x00FF. Same frame with parity bit 1 → `par_err` pulse, `out` unchanged, `slot` = 0.

Source files
------------

// File: rtl/tdm_demux_1x16.sv
`default_nettype none
// ============================================================================
// Module   : tdm_demux_1x16
// Brief    : Receive-side 1:16 TDM demultiplexer. A slot counter follows the
//            serializer's select sequence once a frame-sync marker has been
//            seen. Each strobed bit is sorted into a per-channel shadow
//            register, and every completed frame is published as a registered
//            16-bit word together with a one-cycle valid pulse.
// Options  : TDM_DEMUX_PARITY_EN - when defined, a 17th slot carries even
//            parity over the 16 data bits. The frame is published only when
//            that parity bit matches.
// Revision : 1.0 - initial release
// ============================================================================
module tdm_demux_1x16 #(
  parameter bit RESYNC = 1'b1     // 1: realign on misplaced sync, 0: re-hunt
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        din,
  input  logic        sync_in,
  output logic [15:0] out,
  output logic        frame_valid,
  output logic [4:0]  slot,
  output logic        locked,
  output logic        sync_err,
  output logic        par_err
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [0:0] c_ST_HUNT      = 1'b0;
  localparam logic [0:0] c_ST_RUN       = 1'b1;

  localparam logic [4:0] c_SLOT_FIRST   = 5'd0;
  localparam logic [4:0] c_SLOT_SECOND  = 5'd1;
  localparam logic [4:0] c_SLOT_LASTDAT = 5'd15;

`ifdef TDM_DEMUX_PARITY_EN
  // Slot 15 is kept in the shadow so that it can be checked against parity
  // before the word is published.
  localparam int         c_SH_W         = 16;
  localparam logic [4:0] c_SLOT_PARITY  = 5'd16;
`else
  // Slot 15 goes straight from din into the output word, so the shadow only
  // needs to hold slots 0..14.
  localparam int         c_SH_W         = 15;
`endif

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [4:0]        r_slot;
  logic [c_SH_W-1:0] r_shadow;
  logic [15:0]       r_out;
  logic              r_frame_valid;
  logic              r_sync_err;
  logic              r_par_err;

  // --------------------------------------------------------------------------
  // Next-state decode wires
  // --------------------------------------------------------------------------
  logic [0:0]        w_state_nxt;
  logic [4:0]        w_slot_nxt;
  logic              w_cap;        // write din into shadow[w_cap_idx]
  logic [3:0]        w_cap_idx;
  logic              w_load_out;   // publish w_out_nxt and pulse frame_valid
  logic [15:0]       w_out_nxt;
  logic              w_sync_err;
  logic              w_par_err;
  logic              w_at_first;
  logic              w_at_lastdat;

  assign w_at_first   = (r_slot == c_SLOT_FIRST);
  assign w_at_lastdat = (r_slot == c_SLOT_LASTDAT);

  // Decode the action for the current strobe from the state, slot and marker.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_cap       = 1'b0;
    w_cap_idx   = r_slot[3:0];
    w_load_out  = 1'b0;
    w_out_nxt   = r_out;
    w_sync_err  = 1'b0;
    w_par_err   = 1'b0;

    if (en) begin
      case (r_state)
        c_ST_HUNT: begin
          // Data before the first marker is meaningless and is dropped.
          if (sync_in) begin
            w_cap       = 1'b1;
            w_cap_idx   = 4'd0;
            w_slot_nxt  = c_SLOT_SECOND;
            w_state_nxt = c_ST_RUN;
          end
        end

        default: begin
          if (w_at_first) begin
            if (sync_in) begin
              // This is a normal frame start.
              w_cap      = 1'b1;
              w_cap_idx  = 4'd0;
              w_slot_nxt = c_SLOT_SECOND;
            end else begin
              // The marker is missing, so alignment can no longer be trusted.
              w_sync_err  = 1'b1;
              w_slot_nxt  = c_SLOT_FIRST;
              w_state_nxt = c_ST_HUNT;
            end
          end else if (sync_in) begin
            // The marker arrived mid-frame. The partial frame is never
            // published.
            w_sync_err = 1'b1;
            if (RESYNC) begin
              w_cap      = 1'b1;
              w_cap_idx  = 4'd0;
              w_slot_nxt = c_SLOT_SECOND;
            end else begin
              w_slot_nxt  = c_SLOT_FIRST;
              w_state_nxt = c_ST_HUNT;
            end
          end else if (w_at_lastdat) begin
`ifdef TDM_DEMUX_PARITY_EN
            // Hold the last data bit until the parity slot has been checked.
            w_cap      = 1'b1;
            w_cap_idx  = 4'd15;
            w_slot_nxt = c_SLOT_PARITY;
`else
            w_load_out = 1'b1;
            w_out_nxt  = {din, r_shadow};
            w_slot_nxt = c_SLOT_FIRST;
`endif
          end
`ifdef TDM_DEMUX_PARITY_EN
          else if (r_slot == c_SLOT_PARITY) begin
            // For even parity, din must equal the XOR of the data bits.
            w_slot_nxt = c_SLOT_FIRST;
            if (din == ^r_shadow) begin
              w_load_out = 1'b1;
              w_out_nxt  = r_shadow;
            end else begin
              w_par_err  = 1'b1;
            end
          end
`endif
          else begin
            w_cap      = 1'b1;
            w_slot_nxt = r_slot + 5'd1;
          end
        end
      endcase
    end
  end

  // Advance the frame state machine and the slot counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_HUNT;
      r_slot  <= c_SLOT_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Capture the strobed bit into its channel's shadow bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow <= '0;
    end else begin
      for (int i = 0; i < c_SH_W; i++) begin
        if (w_cap && (w_cap_idx == 4'(i))) begin
          r_shadow[i] <= din;
        end
      end
    end
  end

  // Publish completed frames. The word holds its value between frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else if (w_load_out) begin
      r_out <= w_out_nxt;
    end
  end

  // Generate the single-cycle event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_frame_valid <= w_load_out;
      r_sync_err    <= w_sync_err;
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Pulse the parity error flag for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_par_err;
    end
  end
`else
  // Without the parity slot there is nothing that can mismatch.
  assign r_par_err = 1'b0;
  logic w_unused_par;
  assign w_unused_par = w_par_err;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out         = r_out;
  assign frame_valid = r_frame_valid;
  assign slot        = r_slot;
  assign locked      = (r_state == c_ST_RUN);
  assign sync_err    = r_sync_err;
  assign par_err     = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_1x16.sv
`default_nettype none
// ============================================================================
// Module   : tb_tdm_demux_1x16
// Brief    : Self-checking bench for tdm_demux_1x16. Frames are taken from a
//            vector table, and expected words go through a scoreboard queue.
//            Hand-written sequences cover missing sync, realignment, reset
//            mid-frame and, when TDM_DEMUX_PARITY_EN is defined, parity.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_1x16;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int FRAME_SLOTS = 17;
`else
  localparam int FRAME_SLOTS = 16;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        din;
  logic        sync_in;
  logic [15:0] out;
  logic        frame_valid;
  logic [4:0]  slot;
  logic        locked;
  logic        sync_err;
  logic        par_err;

  tdm_demux_1x16 #(.RESYNC(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .sync_in    (sync_in),
    .out        (out),
    .frame_valid(frame_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err),
    .par_err    (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          gap;   // idle (en = 0) cycles between strobes
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] exp_q[$];
  int          fv_times[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          fv_cnt   = 0;
  int          serr_cnt = 0;
  int          perr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  // Present one strobe, then idle for gap cycles.
  task automatic strobe(input logic d, input logic s, input int gap);
    @(negedge clk);
    en = 1'b1; din = d; sync_in = s;
    repeat (gap) begin
      @(negedge clk);
      en = 1'b0;
    end
  endtask

  task automatic end_burst();
    @(negedge clk);
    en = 1'b0; sync_in = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] d, input int gap);
    exp_q.push_back(d);
    for (int i = 0; i < 16; i++)
      strobe(d[i], 1'(i == 0), (i == FRAME_SLOTS - 1) ? 0 : gap);
`ifdef TDM_DEMUX_PARITY_EN
    strobe(^d, 1'b0, 0);
`endif
    @(posedge clk); #2;
    check("locked_after_frame", 32'(locked), 32'd1);
    check("slot_after_frame", 32'(slot), 32'd0);
  endtask

  // Scoreboard: each frame_valid pulse pops and checks one expected word.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (frame_valid) begin
      fv_cnt++;
      fv_times.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_frame_valid", 32'(frame_valid), 32'd0);
      else check("frame_out", 32'(out), 32'(exp_q.pop_front()));
    end
    if (sync_err) serr_cnt++;
    if (par_err)  perr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          serr0;
    int          fv0;
    logic [15:0] w;

    vecs[0] = '{16'hA5C3, 0};
    vecs[1] = '{16'h0001, 0};
    vecs[2] = '{16'hFFFF, 0};
    vecs[3] = '{16'h0000, 2};
    vecs[4] = '{16'h8000, 1};
    vecs[5] = '{16'h5A5A, 0};

    rst = 1'b1; en = 1'b0; din = 1'b0; sync_in = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out", 32'(out), 32'd0);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_slot", 32'(slot), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven frames; the first three run back-to-back at full rate.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].gap);
      check("tbl_out", 32'(out), 32'(vecs[v].data));
      check("tbl_frame_valid", 32'(frame_valid), 32'd1);
    end
    end_burst();
    @(posedge clk); #2;
    check("fv_one_cycle", 32'(frame_valid), 32'd0);
    check("fv_count_table", 32'(fv_cnt), 32'd6);
    check("fv_spacing_a", 32'(fv_times[1] - fv_times[0]), 32'(FRAME_SLOTS));
    check("fv_spacing_b", 32'(fv_times[2] - fv_times[1]), 32'(FRAME_SLOTS));
    check("no_sync_err_table", 32'(serr_cnt), 32'd0);

    // Missing sync: a slot-0 strobe with no marker.
    strobe(1'b1, 1'b0, 0);
    @(posedge clk); #2;
    check("miss_sync_err", 32'(sync_err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
    check("miss_slot", 32'(slot), 32'd0);
    check("miss_out_hold", 32'(out), 32'h5A5A);
    for (int i = 0; i < FRAME_SLOTS; i++) strobe(1'($urandom_range(0, 1)), 1'b0, 0);
    end_burst();
    @(posedge clk); #2;
    check("miss_no_frame", 32'(fv_cnt), 32'd6);
    check("miss_still_hunting", 32'(locked), 32'd0);
    check("miss_one_pulse", 32'(serr_cnt), 32'd1);

    // Realignment: the marker reappears at slot 7, and 0x1234 follows from there.
    serr0 = serr_cnt;
    for (int i = 0; i < 7; i++) strobe(1'b1, 1'(i == 0), 0);
    w = 16'h1234;
    strobe(w[0], 1'b1, 0);
    @(posedge clk); #2;
    check("resync_err", 32'(sync_err), 32'd1);
    check("resync_slot", 32'(slot), 32'd1);
    check("resync_locked", 32'(locked), 32'd1);
    check("resync_discard", 32'(out), 32'h5A5A);
    exp_q.push_back(w);
    for (int i = 1; i < 16; i++) strobe(w[i], 1'b0, 0);
`ifdef TDM_DEMUX_PARITY_EN
    strobe(^w, 1'b0, 0);
`endif
    @(posedge clk); #2;
    check("resync_out", 32'(out), 32'h1234);
    check("resync_err_count", 32'(serr_cnt - serr0), 32'd1);
    end_burst();

    // Reset at slot 9 clears everything with no clock edge.
    for (int i = 0; i < 9; i++) strobe(1'b1, 1'(i == 0), 0);
    @(posedge clk); #2;
    check("pre_rst_slot", 32'(slot), 32'd9);
    rst = 1'b1; en = 1'b0;
    #1;
    check("async_rst_out", 32'(out), 32'd0);
    check("async_rst_slot", 32'(slot), 32'd0);
    check("async_rst_locked", 32'(locked), 32'd0);
    check("async_rst_fv", 32'(frame_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fv0 = fv_cnt;
    for (int i = 0; i < FRAME_SLOTS; i++) strobe(1'b1, 1'b0, 0);
    end_burst();
    @(posedge clk); #2;
    check("post_rst_no_frame", 32'(fv_cnt), 32'(fv0));
    check("post_rst_hunting", 32'(locked), 32'd0);
    send_frame(16'h3C96, 0);
    end_burst();

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(16'h00FF, 0);
    end_burst();
    w = 16'h00FF;
    for (int i = 0; i < 16; i++) strobe(w[i], 1'(i == 0), 0);
    strobe(1'b1, 1'b0, 0);
    @(posedge clk); #2;
    check("par_err_pulse", 32'(par_err), 32'd1);
    check("par_out_hold", 32'(out), 32'h00FF);
    check("par_slot", 32'(slot), 32'd0);
    check("par_no_fv", 32'(frame_valid), 32'd0);
    end_burst();
    @(posedge clk); #2;
    check("par_err_count", 32'(perr_cnt), 32'd1);
`else
    check("par_err_tied", 32'(perr_cnt), 32'd0);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
